// File: rtl/index_pingpong_buff.sv
// -----------------------------------------------------------------------------
// index_pingpong_buff
//
// Purpose:
//   Double-buffered sparse-index store. Index words arrive over AXI-Stream and
//   are scattered round-robin across Ram_Row row memories: beat k lands in row
//   k[Row_Bits-1:0] at address k >> Row_Bits. Two banks alternate. The write
//   side fills the bank at wr_ptr and the read side drains the bank at rd_ptr.
//   Per-bank full flags and a release handshake (rd_done) keep the producer
//   and the consumer from touching the same bank.
//
// Optional feature (compile-time macro):
//   INDEX_BUFF_TLAST_EN - when defined, a beat carrying s_axis_tlast=1 also
//                         ends the fill. A fill then ends at whichever comes
//                         first, tlast or Beat_end. When undefined,
//                         s_axis_tlast is ignored.
//
// Ports:
//   clki          in   clock for all logic
//   rst           in   synchronous active-high reset
//   start         in   pulse: arm a fill of the next free bank
//   Beat_end      in   index of the last beat of a fill, sampled at start
//   finished      out  1-cycle pulse when a bank is committed full
//   s_axis_tdata  in   stream data (one row word per beat)
//   s_axis_tvalid in   stream valid
//   s_axis_tready out  stream ready, high only while filling
//   s_axis_tlast  in   early fill terminator (INDEX_BUFF_TLAST_EN only)
//   bank_full     out  per-bank full flags
//   rd_ready      out  bank at rd_ptr is full and readable
//   rd_bank       out  current read bank
//   rd_len        out  stored last-beat index of rd_bank
//   enout         in   read enable
//   addrout       in   read address, common to all rows
//   dout          out  row r at [Data_Width*r +: Data_Width]
//   dout_valid    out  dout updated this cycle
//   rd_done       in   pulse: consumer releases rd_bank
// -----------------------------------------------------------------------------
module index_pingpong_buff #(
    parameter int Row_Bits   = 4,
    parameter int Data_Width = 64,
    parameter int Addr_Width = 11
) (
    input  logic                                  clki,
    input  logic                                  rst,
    input  logic                                  start,
    input  logic [Addr_Width+Row_Bits-1:0]        Beat_end,
    output logic                                  finished,
    input  logic [Data_Width-1:0]                 s_axis_tdata,
    input  logic                                  s_axis_tvalid,
    output logic                                  s_axis_tready,
    input  logic                                  s_axis_tlast,
    output logic [1:0]                            bank_full,
    output logic                                  rd_ready,
    output logic                                  rd_bank,
    output logic [Addr_Width+Row_Bits-1:0]        rd_len,
    input  logic                                  enout,
    input  logic [Addr_Width-1:0]                 addrout,
    output logic [Data_Width*(2**Row_Bits)-1:0]   dout,
    output logic                                  dout_valid,
    input  logic                                  rd_done
);

    localparam int Ram_Row   = 2 ** Row_Bits;
    localparam int Cnt_Width = Addr_Width + Row_Bits;
    // Each row memory holds both banks; the bank bit is the address MSB.
    localparam int Row_Depth = 2 ** (Addr_Width + 1);

    typedef enum logic [1:0] {
        W_IDLE,
        W_WAIT,
        W_FILL
    } w_state_t;

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    w_state_t               r_state;
    logic                   r_tready;
    logic                   r_finished;
    logic                   r_wr_ptr;
    logic                   r_rd_ptr;
    logic [1:0]             r_bank_full;
    logic [Cnt_Width-1:0]   r_len [2];
    logic [Cnt_Width-1:0]   r_beat_end;
    logic [Cnt_Width-1:0]   r_beat_cnt;
    logic                   r_dout_valid;

    // -------------------------------------------------------------------------
    // Decoded events
    // -------------------------------------------------------------------------
    logic                   w_beat;
    logic                   w_last;
    logic                   w_commit;
    logic                   w_rd_fire;
    logic                   w_release;
    logic [Row_Bits-1:0]    w_wr_row;
    logic [Addr_Width:0]    w_wr_addr;
    logic [Addr_Width:0]    w_rd_addr;

    // tready is only ever high in W_FILL, so a handshake implies filling.
    assign w_beat = s_axis_tvalid & r_tready;

`ifdef INDEX_BUFF_TLAST_EN
    assign w_last = (r_beat_cnt == r_beat_end) | s_axis_tlast;
`else
    assign w_last = (r_beat_cnt == r_beat_end);
    logic w_unused_tlast;
    assign w_unused_tlast = s_axis_tlast;
`endif

    assign w_commit  = w_beat & w_last;
    assign w_rd_fire = enout & r_bank_full[r_rd_ptr];
    assign w_release = rd_done & r_bank_full[r_rd_ptr];

    assign w_wr_row  = r_beat_cnt[Row_Bits-1:0];
    assign w_wr_addr = {r_wr_ptr, r_beat_cnt[Cnt_Width-1:Row_Bits]};
    assign w_rd_addr = {r_rd_ptr, addrout};

    // -------------------------------------------------------------------------
    // Write-side FSM: arm, wait for a free bank, stream the beats, commit.
    // -------------------------------------------------------------------------
    // NOTE: all state is updated with non-blocking assignments so every
    // register samples the pre-edge values of the others, whatever the
    // statement order.
    always_ff @(posedge clki) begin
        if (rst) begin
            r_state    <= W_IDLE;
            r_tready   <= 1'b0;
            r_finished <= 1'b0;
            r_wr_ptr   <= 1'b0;
            r_beat_end <= '0;
            r_beat_cnt <= '0;
        end else begin
            r_finished <= 1'b0;
            case (r_state)
                W_IDLE: begin
                    if (start) begin
                        r_beat_end <= Beat_end;
                        r_beat_cnt <= '0;
                        if (!r_bank_full[r_wr_ptr]) begin
                            r_state  <= W_FILL;
                            r_tready <= 1'b1;
                        end else begin
                            r_state  <= W_WAIT;
                        end
                    end
                end
                W_WAIT: begin
                    // The target bank is still owned by the consumer.
                    if (!r_bank_full[r_wr_ptr]) begin
                        r_state  <= W_FILL;
                        r_tready <= 1'b1;
                    end
                end
                W_FILL: begin
                    if (w_beat) begin
                        if (w_last) begin
                            r_state    <= W_IDLE;
                            r_tready   <= 1'b0;
                            r_finished <= 1'b1;
                            r_wr_ptr   <= ~r_wr_ptr;
                        end else begin
                            r_beat_cnt <= r_beat_cnt + Cnt_Width'(1);
                        end
                    end
                end
                default: begin
                    r_state  <= W_IDLE;
                    r_tready <= 1'b0;
                end
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Bank ownership. A commit always targets the empty bank at wr_ptr and a
    // release always targets the full bank at rd_ptr. The two can never hit
    // the same flag, so both are allowed to apply on the same edge.
    // -------------------------------------------------------------------------
    always_ff @(posedge clki) begin
        if (rst) begin
            r_bank_full <= 2'b00;
            r_rd_ptr    <= 1'b0;
            r_len[0]    <= '0;
            r_len[1]    <= '0;
        end else begin
            if (w_commit) begin
                r_bank_full[r_wr_ptr] <= 1'b1;
                r_len[r_wr_ptr]       <= r_beat_cnt;
            end
            if (w_release) begin
                r_bank_full[r_rd_ptr] <= 1'b0;
                r_rd_ptr              <= ~r_rd_ptr;
            end
        end
    end

    always_ff @(posedge clki) begin
        if (rst) begin
            r_dout_valid <= 1'b0;
        end else begin
            r_dout_valid <= w_rd_fire;
        end
    end

    // -------------------------------------------------------------------------
    // Row memories. Every row is written only on its own beats and is read in
    // parallel at the common read address.
    // -------------------------------------------------------------------------
    for (genvar g = 0; g < Ram_Row; g++) begin : g_row
        logic [Data_Width-1:0] r_mem [Row_Depth];
        logic [Data_Width-1:0] r_row_q;

        // NOTE: the array has no reset branch. Clearing it would stop it from
        // mapping onto block RAM, and stale words beyond Beat_end are
        // acceptable.
        always_ff @(posedge clki) begin
            if (w_beat && (w_wr_row == Row_Bits'(g))) begin
                r_mem[w_wr_addr] <= s_axis_tdata;
            end
        end

        // Output register resets to zero and holds between reads.
        always_ff @(posedge clki) begin
            if (rst) begin
                r_row_q <= '0;
            end else if (w_rd_fire) begin
                r_row_q <= r_mem[w_rd_addr];
            end
        end

        assign dout[Data_Width*g +: Data_Width] = r_row_q;
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign s_axis_tready = r_tready;
    assign finished      = r_finished;
    assign bank_full     = r_bank_full;
    assign rd_ready      = r_bank_full[r_rd_ptr];
    assign rd_bank       = r_rd_ptr;
    assign rd_len        = r_len[r_rd_ptr];
    assign dout_valid    = r_dout_valid;

endmodule

// File: tb/tb_index_pingpong_buff.sv
// -----------------------------------------------------------------------------
// tb_index_pingpong_buff
//
// Directed bench for index_pingpong_buff. A transaction-level model records
// which beat value went into each bank and tracks the full flags, pointers,
// lengths and the commit pulse. The beat-to-row/address scatter is rebuilt
// only when an expected read word is formed. A compare process checks every
// output against the model on each falling edge outside reset. Literal
// expectations from the scenario list pin the model itself.
// -----------------------------------------------------------------------------
module tb_index_pingpong_buff;

    localparam int RB = 4;
    localparam int DW = 64;
    localparam int AW = 11;
    localparam int NR = 16;
    localparam int CW = AW + RB;

    logic              clki = 1'b0;
    logic              rst = 1'b1;
    logic              start = 1'b0;
    logic [CW-1:0]     Beat_end = '0;
    logic              finished;
    logic [DW-1:0]     s_axis_tdata = '0;
    logic              s_axis_tvalid = 1'b0;
    logic              s_axis_tready;
    logic              s_axis_tlast = 1'b0;
    logic [1:0]        bank_full;
    logic              rd_ready;
    logic              rd_bank;
    logic [CW-1:0]     rd_len;
    logic              enout = 1'b0;
    logic [AW-1:0]     addrout = '0;
    logic [DW*NR-1:0]  dout;
    logic              dout_valid;
    logic              rd_done = 1'b0;

    always #5 clki = ~clki;

    index_pingpong_buff #(
        .Row_Bits   (RB),
        .Data_Width (DW),
        .Addr_Width (AW)
    ) dut (
        .clki          (clki),
        .rst           (rst),
        .start         (start),
        .Beat_end      (Beat_end),
        .finished      (finished),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tready (s_axis_tready),
        .s_axis_tlast  (s_axis_tlast),
        .bank_full     (bank_full),
        .rd_ready      (rd_ready),
        .rd_bank       (rd_bank),
        .rd_len        (rd_len),
        .enout         (enout),
        .addrout       (addrout),
        .dout          (dout),
        .dout_valid    (dout_valid),
        .rd_done       (rd_done)
    );

    int total = 0;
    int bad   = 0;

    // Model: beat value stored per bank by beat index, plus bank ownership.
    logic [DW-1:0] m_mem [0:1][0:63];
    bit            m_full [2];
    int            m_len  [2];
    bit            m_wr  = 1'b0;
    bit            m_rd  = 1'b0;
    bit            m_fin = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // The read word for (bank, addr) is built from the beats that landed there.
    function automatic logic [DW*NR-1:0] exp_word(input bit b, input logic [AW-1:0] a);
        logic [DW*NR-1:0] v;
        int idx;
        v = '0;
        for (int r = 0; r < NR; r++) begin
            idx = int'(a) * NR + r;
            if (idx < 64) v[DW*r +: DW] = m_mem[b][idx];
        end
        return v;
    endfunction

    // Read-path expectation: a read of a full bank yields data one cycle later.
    logic             p_en = 1'b0;
    logic [DW*NR-1:0] e_dout = '0;

    always @(posedge clki) begin
        if (rst) begin
            p_en   <= 1'b0;
            e_dout <= '0;
        end else begin
            p_en <= enout && m_full[m_rd];
            if (enout && m_full[m_rd]) e_dout <= exp_word(m_rd, addrout);
        end
    end

    always @(negedge clki) begin
        if (!rst) begin
            check("dout_valid", 64'(dout_valid), 64'(p_en));
            check("bank_full", 64'(bank_full), 64'({m_full[1], m_full[0]}));
            check("rd_ready", 64'(rd_ready), 64'(m_full[m_rd]));
            check("rd_bank", 64'(rd_bank), 64'(m_rd));
            check("rd_len", 64'(rd_len), 64'(m_len[m_rd]));
            check("finished", 64'(finished), 64'(m_fin));
            for (int r = 0; r < NR; r++)
                check($sformatf("dout_row%0d", r), dout[DW*r +: DW], e_dout[DW*r +: DW]);
        end
    end

    task automatic tick();
        @(posedge clki);
        #1;
    endtask

    task automatic start_fill(input int be);
        Beat_end = CW'(be);
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Sends up to nbeats beats of data base+k; stops early at a commit.
    task automatic stream(input int nbeats, input logic [DW-1:0] base, input bit toggle,
                          input int tlast_at, input int be);
        int k = 0;
        int waitc = 0;
        bit phase = 1'b0;
        bit hs;
        bit last;
        while (k < nbeats) begin
            s_axis_tvalid = toggle ? phase : 1'b1;
            phase = ~phase;
            s_axis_tdata = base + DW'(k);
            s_axis_tlast = (k == tlast_at);
            @(negedge clki);
            hs = s_axis_tvalid && s_axis_tready;
            tick();
            if (hs) begin
                m_mem[m_wr][k] = base + DW'(k);
                last = (k == be);
`ifdef INDEX_BUFF_TLAST_EN
                if (k == tlast_at) last = 1'b1;
`endif
                if (last) begin
                    m_full[m_wr] = 1'b1;
                    m_len[m_wr]  = k;
                    m_wr  = ~m_wr;
                    m_fin = 1'b1;
                    k = nbeats;
                end else begin
                    k++;
                end
                waitc = 0;
            end else begin
                waitc++;
                if (waitc > 50) begin
                    total++;
                    bad++;
                    $display("FAIL stream_timeout: got no handshake for beat %0d within 50 cycles", k);
                    k = nbeats;
                end
            end
        end
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
        if (m_fin) begin
            tick();
            m_fin = 1'b0;
        end
    endtask

    task automatic rd(input int a);
        enout   = 1'b1;
        addrout = AW'(a);
        tick();
        enout   = 1'b0;
    endtask

    task automatic release_bank();
        rd_done = 1'b1;
        tick();
        rd_done = 1'b0;
        if (m_full[m_rd]) begin
            m_full[m_rd] = 1'b0;
            m_rd = ~m_rd;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        m_full[0] = 1'b0;
        m_full[1] = 1'b0;
        m_len[0]  = 0;
        m_len[1]  = 0;
        m_wr  = 1'b0;
        m_rd  = 1'b0;
        m_fin = 1'b0;
        tick();
        rst = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        for (int b = 0; b < 2; b++)
            for (int i = 0; i < 64; i++) m_mem[b][i] = '0;
        m_full[0] = 1'b0;
        m_full[1] = 1'b0;
        m_len[0]  = 0;
        m_len[1]  = 0;

        // Reset state.
        repeat (3) tick();
        rst = 1'b0;
        @(negedge clki);
        check("rst_tready", 64'(s_axis_tready), 64'd0);
        check("rst_bank_full", 64'(bank_full), 64'd0);
        check("rst_finished", 64'(finished), 64'd0);
        check("rst_dout_valid", 64'(dout_valid), 64'd0);
        check("rst_dout_row0", dout[63:0], 64'd0);
        check("rst_rd_len", 64'(rd_len), 64'd0);
        tick();

        // 32 beats of data=k into bank 0, then read back addresses 0 and 1.
        start_fill(31);
        stream(32, 64'd0, 1'b0, -1, 31);
        @(negedge clki);
        check("fill1_bank_full", 64'(bank_full), 64'd1);
        check("fill1_rd_len", 64'(rd_len), 64'd31);
        tick();
        rd(0);
        rd(1);
        @(negedge clki);
        check("fill1_valid", 64'(dout_valid), 64'd1);
        check("fill1_row5_addr1", dout[DW*5 +: DW], 64'd21);
        check("fill1_row15_addr1", dout[DW*15 +: DW], 64'd31);
        tick();
        release_bank();
        @(negedge clki);
        check("rel1_bank_full", 64'(bank_full), 64'd0);
        tick();

        // Both banks full, a third start must wait for a release.
        start_fill(15);
        stream(16, 64'd100, 1'b0, -1, 15);
        start_fill(15);
        stream(16, 64'd200, 1'b0, -1, 15);
        start_fill(15);
        tick();
        @(negedge clki);
        check("wait_bank_full", 64'(bank_full), 64'd3);
        check("wait_tready", 64'(s_axis_tready), 64'd0);
        tick();
        release_bank();
        @(negedge clki);
        check("wait_tready_rel", 64'(s_axis_tready), 64'd0);
        tick();
        @(negedge clki);
        check("wait_tready_rise", 64'(s_axis_tready), 64'd1);
        tick();
        stream(16, 64'd300, 1'b0, -1, 15);
        rd(0);
        @(negedge clki);
        check("b0_row3", dout[DW*3 +: DW], 64'd203);
        tick();
        release_bank();
        rd(0);
        @(negedge clki);
        check("b1_row7", dout[DW*7 +: DW], 64'd307);
        tick();
        release_bank();

        // Throttled stream: tvalid every other cycle.
        start_fill(31);
        stream(32, 64'd0, 1'b1, -1, 31);
        rd(1);
        @(negedge clki);
        check("tog_row5_addr1", dout[DW*5 +: DW], 64'd21);
        check("tog_rd_len", 64'(rd_len), 64'd31);
        tick();
        rd(0);
        release_bank();

        // Reset in the middle of a fill.
        start_fill(31);
        stream(10, 64'd5000, 1'b0, -1, 31);
        do_reset();
        @(negedge clki);
        check("mid_rst_tready", 64'(s_axis_tready), 64'd0);
        check("mid_rst_bank_full", 64'(bank_full), 64'd0);
        check("mid_rst_finished", 64'(finished), 64'd0);
        tick();
        start_fill(15);
        stream(16, 64'd7000, 1'b0, -1, 15);
        @(negedge clki);
        check("post_rst_rd_len", 64'(rd_len), 64'd15);
        tick();
        rd(0);
        @(negedge clki);
        check("post_rst_row9", dout[DW*9 +: DW], 64'd7009);
        tick();
        release_bank();

        // tlast on beat 7.
        start_fill(31);
        stream(32, 64'd900, 1'b0, 7, 31);
        @(negedge clki);
`ifdef INDEX_BUFF_TLAST_EN
        check("tlast_rd_len", 64'(rd_len), 64'd7);
`else
        check("tlast_rd_len", 64'(rd_len), 64'd31);
`endif
        tick();
        rd(0);
        rd(1);
        release_bank();
        repeat (2) tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
